fetch_sequencer: RTL and testbench

Instruction-fetch controller that owns the program counter and sequences reads from the 16-word instruction memory.
- Presents fetched words to decode/execute through a valid/ready handshake.
- Applies branch/jump redirects from execute.
- Stops on the halt opcode (6'h3F) and traps illegal fetch addresses.
- Sits between instruction memory and the decode stage.
- Tolerates both same-cycle (combinational) and multi-cycle memory responses.

---
 rtl/cpu_pkg.sv | 15 +
 rtl/fetch_sequencer.sv | 66 ++++++
 tb/tb_fetch_sequencer.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: opcodes, fetch state encoding and address legality shared by the fetch and data-memory controllers
package cpu_pkg;
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_IMEM_WORDS = 16;
  localparam logic [5:0] OP_ADD = 6'h00;
  localparam logic [5:0] OP_ADDI = 6'h01;
  localparam logic [5:0] OP_ORI = 6'h0D;
  localparam logic [5:0] OP_BEQ = 6'h30;
  localparam logic [5:0] OP_HALT = 6'h3F;
  typedef enum logic [2:0] {IDLE, REQ, HOLD, HALT, FAULT} fetch_state_t;
  // word aligned and inside the first `words` words; callers zero-extend to 64 bits
  function automatic logic addr_legal(input logic [63:0] a, input int words);
    return (a[1:0] == 2'b00) && ((a >> 2) < 64'(words));
  endfunction
endpackage

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the pc, fetches one word at a time from instruction memory
// and hands it to decode over valid/ready, applying redirects, halt and address traps
module fetch_sequencer #(
  parameter int ADDR_W = cpu_pkg::DEF_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int IMEM_WORDS = cpu_pkg::DEF_IMEM_WORDS,
  parameter logic [5:0] HALT_OP = cpu_pkg::OP_HALT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic imem_ack,
  input  logic [31:0] imem_rdata,
  output logic inst_valid,
  output logic [31:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic inst_ready,
  input  logic redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic halted,
  output logic fault
);
  import cpu_pkg::*;
  fetch_state_t state, state_nx;
  logic [ADDR_W-1:0] pc, next_pc;
  logic accept, is_halt, start_ok, next_ok;
  assign accept = (state == HOLD) && inst_ready;
  assign is_halt = inst[31:26] == HALT_OP;
  assign next_pc = redirect ? redirect_pc : pc + ADDR_W'(4);
  assign start_ok = addr_legal(64'(RESET_PC), IMEM_WORDS);
  assign next_ok = addr_legal(64'(next_pc), IMEM_WORDS);
  assign imem_addr = pc;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  end
  // halt beats redirect; an illegal target is trapped before it is ever requested
  always_comb begin
    state_nx = state;
    if (state == IDLE && start) state_nx = start_ok ? REQ : FAULT;
    if (state == REQ && imem_ack) state_nx = HOLD;
    if (accept) state_nx = is_halt ? HALT : next_ok ? REQ : FAULT;
  end
  always_comb begin
    imem_req = state == REQ;
    inst_valid = state == HOLD;
    halted = state == HALT;
    fault = state == FAULT;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
      inst <= '0;
      inst_pc <= '0;
    end else begin
      if (state == IDLE && start) pc <= RESET_PC;
      if (state == REQ && imem_ack) begin
        inst <= imem_rdata;
        inst_pc <= pc;
      end
      if (accept && !is_halt) pc <= next_pc;
    end
  end
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: scenario tasks plus a randomized run against a pc-level reference model
module tb_fetch_sequencer;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, inst_ready = 1'b0, redirect = 1'b0;
  logic imem_req, imem_ack, inst_valid, halted, fault;
  logic [31:0] imem_addr, imem_rdata, inst, inst_pc;
  logic [31:0] redirect_pc = '0;
  logic [31:0] mem [16];
  int lat = 0, wcnt = 0, checks = 0, passed = 0;

  fetch_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .inst_ready(inst_ready),
    .redirect(redirect), .redirect_pc(redirect_pc), .halted(halted), .fault(fault)
  );

  always #5 clk = ~clk;
  // memory model: ack after `lat` wait cycles, 0 means same-cycle
  assign imem_ack = imem_req && (wcnt >= lat);
  assign imem_rdata = imem_ack ? mem[imem_addr[5:2]] : 32'hDEAD_BEEF;
  always @(posedge clk) wcnt <= (imem_req && !imem_ack) ? wcnt + 1 : 0;

  function automatic bit legal(input logic [31:0] a);
    return (a % 32'd4 == 32'd0) && (a / 32'd4 < 32'd16);
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic load_program;
    for (int i = 0; i < 16; i++) mem[i] = {6'h0D, 26'(i * 7 + 3)};
    mem[0] = 32'h04010005;
    mem[1] = 32'h04010008;
    mem[2] = 32'h00221800;
    mem[12] = 32'hFC000000;
  endtask

  task automatic do_reset;
    rst_n = 1'b0; start = 1'b0; inst_ready = 1'b0; redirect = 1'b0; lat = 0;
    tick(2);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_valid(output int cyc, output bit ok);
    cyc = 0;
    while (!inst_valid && cyc < 50) begin
      tick();
      cyc++;
    end
    ok = inst_valid;
  endtask

  task automatic accept_inst(input bit r, input logic [31:0] t);
    inst_ready = 1'b1; redirect = r; redirect_pc = t;
    tick();
    inst_ready = 1'b0; redirect = 1'b0; redirect_pc = $urandom;
  endtask

  task automatic test_reset;
    int n;
    do_reset;
    checks++; if ({imem_req, inst_valid, halted, fault} !== 4'b0) $display("FAIL reset_flags: got %b want 0000", {imem_req, inst_valid, halted, fault}); else passed++;
    checks++; if ({imem_addr, inst, inst_pc} !== 96'h0) $display("FAIL reset_regs: got addr=%h inst=%h pc=%h want zeros", imem_addr, inst, inst_pc); else passed++;
    n = 0;
    repeat (5) begin tick(); if (imem_req) n++; end
    checks++; if (n != 0) $display("FAIL idle_no_req: got %0d req cycles want 0", n); else passed++;
  endtask

  task automatic test_sequence;
    load_program;
    do_reset;
    inst_ready = 1'b1;
    pulse_start;
    checks++; if ({imem_req, imem_addr} !== {1'b1, 32'h00}) $display("FAIL seq_req0: got req=%b addr=%h want 1 00", imem_req, imem_addr); else passed++;
    tick();
    checks++; if ({inst_valid, imem_req, inst, inst_pc} !== {2'b10, mem[0], 32'h00}) $display("FAIL seq_inst0: got v=%b req=%b inst=%h pc=%h", inst_valid, imem_req, inst, inst_pc); else passed++;
    tick();
    checks++; if ({imem_req, imem_addr} !== {1'b1, 32'h04}) $display("FAIL seq_req4: got req=%b addr=%h want 1 04", imem_req, imem_addr); else passed++;
    tick();
    checks++; if ({inst_valid, inst, inst_pc} !== {1'b1, 32'h04010008, 32'h04}) $display("FAIL seq_inst4: got v=%b inst=%h pc=%h want 1 04010008 04", inst_valid, inst, inst_pc); else passed++;
    tick();
    checks++; if ({imem_req, imem_addr} !== {1'b1, 32'h08}) $display("FAIL seq_req8: got req=%b addr=%h want 1 08", imem_req, imem_addr); else passed++;
    inst_ready = 1'b0;
  endtask

  task automatic test_halt;
    int c, n; bit ok;
    load_program;
    do_reset;
    pulse_start;
    wait_valid(c, ok);
    accept_inst(1'b1, 32'h30);
    wait_valid(c, ok);
    checks++; if ({ok, inst, inst_pc} !== {1'b1, 32'hFC000000, 32'h30}) $display("FAIL halt_fetch: got ok=%b inst=%h pc=%h want 1 fc000000 30", ok, inst, inst_pc); else passed++;
    accept_inst(1'b1, 32'h00);
    checks++; if ({halted, inst_valid, fault, imem_req} !== 4'b1000) $display("FAIL halt_state: got h/v/f/req=%b want 1000", {halted, inst_valid, fault, imem_req}); else passed++;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      start = (i == 5);
      tick();
      if (imem_req || inst_valid) n++;
    end
    start = 1'b0;
    checks++; if (n != 0 || halted !== 1'b1) $display("FAIL halt_sticky: got %0d active cycles halted=%b want 0 1", n, halted); else passed++;
  endtask

  task automatic test_redirect;
    int c; bit ok;
    load_program;
    do_reset;
    pulse_start;
    wait_valid(c, ok);
    accept_inst(1'b1, 32'h2C);
    wait_valid(c, ok);
    checks++; if ({ok, inst, inst_pc} !== {1'b1, mem[11], 32'h2C}) $display("FAIL redir_2c: got ok=%b inst=%h pc=%h want 1 %h 2c", ok, inst, inst_pc, mem[11]); else passed++;
    accept_inst(1'b1, 32'h1C);
    checks++; if ({imem_req, imem_addr} !== {1'b1, 32'h1C}) $display("FAIL redir_req: got req=%b addr=%h want 1 1c", imem_req, imem_addr); else passed++;
    wait_valid(c, ok);
    checks++; if ({ok, inst, inst_pc} !== {1'b1, mem[7], 32'h1C}) $display("FAIL redir_1c: got ok=%b inst=%h pc=%h want 1 %h 1c", ok, inst, inst_pc, mem[7]); else passed++;
  endtask

  task automatic test_stall;
    int c, bad; bit ok;
    load_program;
    do_reset;
    pulse_start;
    wait_valid(c, ok);
    accept_inst(1'b0, 32'h0);
    wait_valid(c, ok);
    accept_inst(1'b0, 32'h0);
    wait_valid(c, ok);
    checks++; if ({ok, inst, inst_pc} !== {1'b1, 32'h00221800, 32'h08}) $display("FAIL stall_inst: got ok=%b inst=%h pc=%h want 1 00221800 08", ok, inst, inst_pc); else passed++;
    bad = 0;
    repeat (3) begin
      tick();
      if (inst !== 32'h00221800 || inst_pc !== 32'h08 || inst_valid !== 1'b1 || imem_req !== 1'b0) bad++;
    end
    checks++; if (bad != 0) $display("FAIL stall_hold: got %0d unstable cycles want 0", bad); else passed++;
    accept_inst(1'b0, 32'h0);
    checks++; if ({imem_req, imem_addr} !== {1'b1, 32'h0C}) $display("FAIL stall_resume: got req=%b addr=%h want 1 0c", imem_req, imem_addr); else passed++;
  endtask

  task automatic test_latency;
    int c, n, bad; bit ok;
    load_program;
    do_reset;
    lat = 3;
    pulse_start;
    n = 0; bad = 0;
    while (!inst_valid && n < 30) begin
      if (imem_req !== 1'b1 || imem_addr !== 32'h0) bad++;
      tick();
      n++;
    end
    checks++; if (bad != 0 || n != lat + 1) $display("FAIL lat_hold: got %0d unstable, %0d cycles want 0, %0d", bad, n, lat + 1); else passed++;
    checks++; if ({inst, inst_pc} !== {mem[0], 32'h0}) $display("FAIL lat_data: got inst=%h pc=%h want %h 0", inst, inst_pc, mem[0]); else passed++;
    accept_inst(1'b0, 32'h0);
    wait_valid(c, ok);
    checks++; if (!ok || c + 1 != lat + 2) $display("FAIL lat_period: got %0d cycles want %0d", c + 1, lat + 2); else passed++;
    checks++; if ({inst, inst_pc} !== {mem[1], 32'h04}) $display("FAIL lat_data4: got inst=%h pc=%h want %h 04", inst, inst_pc, mem[1]); else passed++;
  endtask

  task automatic test_illegal;
    logic [31:0] tg [3];
    logic [31:0] exp_addr;
    int c, n; bit ok;
    tg = '{32'h42, 32'h40, 32'h3C};
    load_program;
    for (int i = 0; i < 3; i++) begin
      do_reset;
      pulse_start;
      wait_valid(c, ok);
      accept_inst(1'b1, tg[i]);
      if (i == 2) begin
        wait_valid(c, ok);
        accept_inst(1'b0, 32'h0);
      end
      exp_addr = (i == 2) ? 32'h40 : tg[i];
      checks++; if ({fault, inst_valid, imem_req, imem_addr} !== {3'b100, exp_addr}) $display("FAIL illegal_%h: got f/v/req=%b addr=%h want 100 %h", exp_addr, {fault, inst_valid, imem_req}, imem_addr, exp_addr); else passed++;
      n = 0;
      repeat (10) begin tick(); if (imem_req) n++; end
      checks++; if (n != 0 || fault !== 1'b1) $display("FAIL illegal_sticky_%h: got %0d req cycles fault=%b want 0 1", exp_addr, n, fault); else passed++;
    end
  endtask

  task automatic test_async_reset;
    int c, n; bit ok;
    load_program;
    do_reset;
    pulse_start;
    wait_valid(c, ok);
    accept_inst(1'b1, 32'h14);
    wait_valid(c, ok);
    lat = 5;
    accept_inst(1'b0, 32'h0);
    tick(2);
    checks++; if ({imem_req, imem_addr, inst_pc} !== {1'b1, 32'h18, 32'h14}) $display("FAIL areset_pre: got req=%b addr=%h pc=%h want 1 18 14", imem_req, imem_addr, inst_pc); else passed++;
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({imem_req, inst_valid, halted, fault, imem_addr, inst, inst_pc} !== 100'h0) $display("FAIL areset_now: got req=%b v=%b addr=%h inst=%h pc=%h want zeros", imem_req, inst_valid, imem_addr, inst, inst_pc); else passed++;
    @(negedge clk) rst_n = 1'b1;
    n = 0;
    repeat (10) begin tick(); if (imem_req || inst_valid) n++; end
    checks++; if (n != 0) $display("FAIL areset_idle: got %0d active cycles want 0", n); else passed++;
    lat = 0;
    pulse_start;
    checks++; if ({imem_req, imem_addr} !== {1'b1, 32'h0}) $display("FAIL areset_restart: got req=%b addr=%h want 1 0", imem_req, imem_addr); else passed++;
  endtask

  task automatic test_random;
    logic [31:0] exp_pc, tgt, w;
    int c, idx; bit ok, r;
    for (int i = 0; i < 16; i++) begin
      w = $urandom;
      if (w[31:26] == 6'h3F) w[31] = 1'b0;
      mem[i] = w;
    end
    do_reset;
    lat = $urandom_range(0, 3);
    pulse_start;
    exp_pc = 32'h0;
    for (int k = 0; k < 40; k++) begin
      wait_valid(c, ok);
      idx = int'(exp_pc / 32'd4);
      checks++; if (!ok || c != lat + 1) $display("FAIL rand_period[%0d]: got %0d cycles want %0d", k, c, lat + 1); else passed++;
      checks++; if ({imem_req, inst, inst_pc} !== {1'b0, mem[idx], exp_pc}) $display("FAIL rand_inst[%0d]: got req=%b inst=%h pc=%h want 0 %h %h", k, imem_req, inst, inst_pc, mem[idx], exp_pc); else passed++;
      tick($urandom_range(0, 2));
      lat = $urandom_range(0, 3);
      r = $urandom_range(0, 9) < 3;
      tgt = 32'($urandom_range(0, 15)) * 32'd4;
      exp_pc = r ? tgt : exp_pc + 32'd4;
      accept_inst(r, tgt);
      if (legal(exp_pc)) begin
        checks++; if ({imem_req, imem_addr} !== {1'b1, exp_pc}) $display("FAIL rand_next[%0d]: got req=%b addr=%h want 1 %h", k, imem_req, imem_addr, exp_pc); else passed++;
      end else begin
        checks++; if ({fault, imem_req} !== 2'b10) $display("FAIL rand_fault[%0d]: got f/req=%b want 10 at %h", k, {fault, imem_req}, exp_pc); else passed++;
        do_reset;
        pulse_start;
        exp_pc = 32'h0;
      end
    end
  endtask

  initial begin
    test_reset;
    test_sequence;
    test_halt;
    test_redirect;
    test_stall;
    test_latency;
    test_illegal;
    test_async_reset;
    test_random;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
